// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and LFSR constants for the reaction game
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM      = 3'd1,
        ST_WAIT     = 3'd2,
        ST_RESULT   = 3'd3,
        ST_GAMEOVER = 3'd4
    } game_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Tap mask for x^16 + x^15 + x^13 + x^4 (bits 15, 14, 12, 3)
    localparam logic [15:0] LFSR_TAPS = 16'hD008;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/reaction_game_nch_if.sv
// rtl/reaction_game_nch_if.sv - player-facing signals of the reaction game
interface reaction_game_nch_if #(
    parameter int N_CH    = 4,
    parameter int SCORE_W = 8,
    parameter int LIVES   = 3
);
    localparam int LIVES_W = $clog2(LIVES + 1);

    logic               start;
    logic [N_CH-1:0]    button;
    logic [N_CH-1:0]    led;
    logic [SCORE_W-1:0] score;
    logic [LIVES_W-1:0] lives_left;
    logic               hit;
    logic               miss;
    logic               game_over;

    modport master (
        output start, button,
        input  led, score, lives_left, hit, miss, game_over
    );

    modport slave (
        input  start, button,
        output led, score, lives_left, hit, miss, game_over
    );

endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, stability counter and press event for one button
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // cnt counts consecutive synchronised samples that disagree with the accepted level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                cnt   <= '0;
                level <= sync2;
                press <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/reaction_game_nch.sv
// rtl/reaction_game_nch.sv - N-channel reaction game: random target LED, timed press, score and lives
module reaction_game_nch
    import game_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int DEBOUNCE_CYC = 4,
    parameter int TIMEOUT_INIT = 64,
    parameter int TIMEOUT_STEP = 8,
    parameter int TIMEOUT_MIN  = 16,
    parameter int LIVES        = 3,
    parameter int SCORE_W      = 8
) (
    input logic                 osc_clk,
    input logic                 reset,
    reaction_game_nch_if.slave  bus
);
    localparam int LIVES_W = $clog2(LIVES + 1);
    localparam int WIN_W   = $clog2(TIMEOUT_INIT + 1);
    localparam int CH_W    = $clog2(N_CH);

    logic [N_CH-1:0]    press;
    logic [15:0]        lfsr;
    logic [7:0]         tgt_mod;
    game_state_t        state;
    logic [N_CH-1:0]    led_q;
    logic [SCORE_W-1:0] score_q;
    logic [LIVES_W-1:0] lives_q;
    logic               hit_q;
    logic               miss_q;
    logic               over_q;
    logic [WIN_W-1:0]   window;
    logic [WIN_W-1:0]   timer;
    logic               press_any;
    logic               press_hit;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_deb (
            .clk   (osc_clk),
            .rst   (reset),
            .button(bus.button[i]),
            .press (press[i])
        );
    end

    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign tgt_mod   = lfsr[7:0] % 8'(N_CH);
    // led holds the one-hot target during WAIT, so a hit is an event vector equal to it
    assign press_any = |press;
    assign press_hit = (press == led_q);

    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            led_q   <= '0;
            score_q <= '0;
            lives_q <= LIVES_W'(LIVES);
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            over_q  <= 1'b0;
            window  <= WIN_W'(TIMEOUT_INIT);
            timer   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_GAMEOVER: begin
                    if (bus.start) begin
                        score_q <= '0;
                        lives_q <= LIVES_W'(LIVES);
                        window  <= WIN_W'(TIMEOUT_INIT);
                        led_q   <= '0;
                        over_q  <= 1'b0;
                        state   <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    led_q <= N_CH'(1) << tgt_mod[CH_W-1:0];
                    timer <= window;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    timer <= timer - WIN_W'(1);
                    // a press in the expiry cycle still takes priority over the timeout
                    if (press_any || timer == WIN_W'(1)) begin
                        led_q <= '0;
                        state <= ST_RESULT;
                        if (press_any && press_hit) begin
                            hit_q <= 1'b1;
                            if (score_q != '1) begin
                                score_q <= score_q + SCORE_W'(1);
                            end
                            if (window >= WIN_W'(TIMEOUT_MIN + TIMEOUT_STEP)) begin
                                window <= window - WIN_W'(TIMEOUT_STEP);
                            end else begin
                                window <= WIN_W'(TIMEOUT_MIN);
                            end
                        end else begin
                            miss_q  <= 1'b1;
                            lives_q <= lives_q - LIVES_W'(1);
                        end
                    end
                end
                ST_RESULT: begin
                    hit_q  <= 1'b0;
                    miss_q <= 1'b0;
                    if (miss_q && lives_q == '0) begin
                        led_q  <= '1;
                        over_q <= 1'b1;
                        state  <= ST_GAMEOVER;
                    end else begin
                        state <= ST_ARM;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.led        = led_q;
    assign bus.score      = score_q;
    assign bus.lives_left = lives_q;
    assign bus.hit        = hit_q;
    assign bus.miss       = miss_q;
    assign bus.game_over  = over_q;

endmodule

// File: doc/reaction_game_nch.md
REACTION_GAME_NCH -- requirements
Module: reaction_game_nch

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of button/LED channels, 2..16.
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 4: consecutive stable cycles required to accept a button level.
REQ-003 SHALL have parameter TIMEOUT_INIT, default 64: initial response window, in cycles.
REQ-004 SHALL have parameters TIMEOUT_STEP, default 8, and TIMEOUT_MIN, default 16: window shrink per hit, and window floor.
REQ-005 SHALL have parameters LIVES, default 3, and SCORE_W, default 8: misses allowed before game over, and score width.
REQ-006 SHALL have port osc_clk, input, 1 bit: single clock; all state on rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: synchronous level; sampled high in IDLE or GAMEOVER, it starts a game.
REQ-009 SHALL have port button, input, N_CH bits: raw asynchronous push-buttons, active-high.
REQ-010 SHALL have port led, output, N_CH bits: one-hot target in WAIT; all ones in GAMEOVER; zero otherwise.
REQ-011 SHALL have port score, output, SCORE_W bits: hit count, saturating.
REQ-012 SHALL have port lives_left, output, clog2(LIVES+1) bits: remaining lives.
REQ-013 SHALL have ports hit and miss, output, 1 bit each: one-cycle pulses in RESULT.
REQ-014 SHALL have port game_over, output, 1 bit: high while in GAMEOVER.

Function
REQ-015 SHALL synchronise each button through 2 flops, then debounce per channel; debounced level changes only after DEBOUNCE_CYC identical synchronised samples.
REQ-016 SHALL produce a one-cycle press event per channel on the debounced rising edge; a held button SHALL produce no further events.
REQ-017 SHALL run a 16-bit maximal-length LFSR (taps 16,15,13,4) advancing every cycle; seed 16'hACE1; never zero.
REQ-018 SHALL have FSM states IDLE, ARM, WAIT, RESULT, GAMEOVER.
REQ-019 SHALL transition IDLE->ARM on start; clear score, lives_left:=LIVES, window:=TIMEOUT_INIT.
REQ-020 ARM (1 cycle) SHALL latch target := LFSR[7:0] mod N_CH, load timer := window, go to WAIT.
REQ-021 WAIT SHALL drive led = 1<<target and decrement the timer each cycle.
REQ-022 In WAIT, a press event on exactly the target channel with no other event that cycle SHALL be a hit; go to RESULT.
REQ-023 In WAIT, any event on a non-target channel (including simultaneously with target) SHALL be a miss; go to RESULT.
REQ-024 In WAIT, timer reaching 0 with no event SHALL be a miss; a valid target press in the same cycle as expiry SHALL count as a hit.
REQ-025 RESULT (1 cycle) SHALL pulse hit or miss. On hit: score+1, saturating at all-ones; window := max(window-TIMEOUT_STEP, TIMEOUT_MIN).
REQ-026 On miss, RESULT SHALL decrement lives_left; if it becomes 0, go to GAMEOVER, else to ARM.
REQ-027 On hit, RESULT SHALL go to ARM.
REQ-028 Press events outside WAIT SHALL be ignored; start outside IDLE/GAMEOVER SHALL be ignored.
REQ-029 GAMEOVER SHALL hold score and go to ARM on start, with the same initialisation as IDLE->ARM.

Reset
REQ-030 Reset SHALL asynchronously force: state IDLE, led 0, score 0, lives_left LIVES, hit/miss/game_over 0, LFSR seed, debouncers to released, timer 0.
REQ-031 Reset asserted mid-game SHALL abandon the round with no hit/miss pulse; operation resumes on the first clock edge after deassertion.

Structure
REQ-032 Shared package game_pkg SHALL hold the FSM state encoding, LFSR seed and tap constants.
REQ-033 SHALL instantiate one sub-module btn_debounce per channel (synchroniser + counter + edge event), generated N_CH times.

Verification (N_CH=4, defaults)
REQ-034 Debounce: button[1] glitches high 3 cycles then low -> no event; held 10 cycles -> exactly one event, 2+4 cycles after the rise.
REQ-035 Hit: start, press target within window -> hit pulse 1 cycle, score=1; next window=56; after 6 hits window=16 and stays 16.
REQ-036 Timeout: start, no press -> miss after 64 WAIT cycles, lives_left 3->2; three timeouts -> game_over=1, led=4'b1111.
REQ-037 Wrong/simultaneous: target plus a non-target pressed the same cycle -> miss, score unchanged.
REQ-038 Saturation/restart: SCORE_W=2, 5 hits -> score=3; start in GAMEOVER -> score=0, lives_left=3.
REQ-039 Reset mid-WAIT: assert reset asynchronously -> led=0, state IDLE immediately, no hit/miss pulse.
